regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/rf_scoreboard.sv | 69 ++++++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the forwarding-priority helper for the multi-port
// register file.
package regfile_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int DEFAULT_NREG = 32;

    // Source chosen for a read port's data.
    typedef enum logic [1:0] {
        SEL_STORED = 2'd0,
        SEL_WD0    = 2'd1,
        SEL_WD1    = 2'd2
    } byp_sel_e;

    // Write port 1 wins over port 0; the hits already include the write
    // enable and the "index is not x0" qualification.
    function automatic byp_sel_e bypass_sel(input logic hit0, input logic hit1);
        if (hit1) begin
            return SEL_WD1;
        end else if (hit0) begin
            return SEL_WD0;
        end else begin
            return SEL_STORED;
        end
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on write-back, plus a per-read-port busy lookup.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = DEFAULT_NREG,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0_i,
    input  logic [AW-1:0]     wa0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     wa1_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic [NRD*AW-1:0] ra_i,
    output logic [NREG-1:0]   busy_vec_o,
    output logic [NRD-1:0]    rbusy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy state: a new issue beats a same-cycle write-back; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (iss_en_i && (iss_rd_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((we0_i && (wa0_i == AW'(i))) || (we1_i && (wa1_i == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rbusy
        logic [AW-1:0] ra_k;
        logic          wb_hit;
        logic          iss_hit;

        assign ra_k    = ra_i[k*AW +: AW];
        assign wb_hit  = (we0_i && (wa0_i == ra_k)) || (we1_i && (wa1_i == ra_k));
        assign iss_hit = iss_en_i && (iss_rd_i == ra_k);

        if (BYPASS != 0) begin : g_byp
            // A completing write-back hides the stale busy bit unless a new
            // producer is issued to the same register in the same cycle.
            assign rbusy_o[k] = busy_q[ra_k] & ~(wb_hit & ~iss_hit);
        end else begin : g_nobyp
            assign rbusy_o[k] = busy_q[ra_k];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with optional write-to-read forwarding,
// a link-register mirror and an issue/write-back scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREG     = DEFAULT_NREG,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int LINK_IDX = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic [XLEN-1:0]     link_q,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Next register contents: port 1 overrides port 0 on a shared index; x0 stays 0.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREG; i++) begin
            if (we1 && (wa1 == AW'(i))) begin
                regs_d[i] = wd1;
            end else if (we0 && (wa0 == AW'(i))) begin
                regs_d[i] = wd0;
            end
        end
        regs_d[0] = '0;
    end

    // Register array, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra_k;
        logic [XLEN-1:0] stored;
        logic            hit0;
        logic            hit1;
        byp_sel_e        sel;

        assign ra_k   = ra[k*AW +: AW];
        assign stored = (ra_k == '0) ? '0 : regs_q[ra_k];

        if (BYPASS != 0) begin : g_byp
            assign hit0 = we0 && (wa0 == ra_k) && (ra_k != '0);
            assign hit1 = we1 && (wa1 == ra_k) && (ra_k != '0);
        end else begin : g_nobyp
            assign hit0 = 1'b0;
            assign hit1 = 1'b0;
        end

        assign sel = bypass_sel(hit0, hit1);
        assign rd[k*XLEN +: XLEN] = (sel == SEL_WD1) ? wd1 :
                                    (sel == SEL_WD0) ? wd0 : stored;
    end

    if (LINK_IDX == 0) begin : g_link_zero
        assign link_q = '0;
    end else begin : g_link
        assign link_q = regs_q[LINK_IDX];
    end

    rf_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .we0_i      (we0),
        .wa0_i      (wa0),
        .we1_i      (we1),
        .wa1_i      (wa1),
        .iss_en_i   (iss_en),
        .iss_rd_i   (iss_rd),
        .ra_i       (ra),
        .busy_vec_o (busy_vec),
        .rbusy_o    (rbusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default configuration plus a 64-bit, 16-entry,
// three-read-port instance. Inputs change on the falling edge; outputs are
// sampled 1 time unit later, before the next rising edge.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default instance (XLEN=32, NREG=32, NRD=2)
    logic        we0, we1, iss_en;
    logic [4:0]  wa0, wa1, iss_rd;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic [31:0] link_q;
    logic [31:0] busy_vec;

    // Wide instance (XLEN=64, NREG=16, NRD=3)
    logic         we0_w, we1_w, iss_en_w;
    logic [3:0]   wa0_w, wa1_w, iss_rd_w;
    logic [63:0]  wd0_w, wd1_w;
    logic [11:0]  ra_w;
    logic [191:0] rd_w;
    logic [2:0]   rbusy_w;
    logic [63:0]  link_q_w;
    logic [15:0]  busy_vec_w;

    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [63:0] obs_v;
    int vectors = 0;
    int errors  = 0;

    regfile_mp u_dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd), .rbusy(rbusy),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .link_q(link_q), .busy_vec(busy_vec)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3)) u_dut_w (
        .clk(clk), .rst(rst),
        .we0(we0_w), .wa0(wa0_w), .wd0(wd0_w),
        .we1(we1_w), .wa1(wa1_w), .wd1(wd1_w),
        .ra(ra_w), .rd(rd_w), .rbusy(rbusy_w),
        .iss_en(iss_en_w), .iss_rd(iss_rd_w),
        .link_q(link_q_w), .busy_vec(busy_vec_w)
    );

    // Clock
    always #5 clk = ~clk;

    // Drivers
    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_en = 1'b0; iss_rd = '0;
        we0_w = 1'b0; wa0_w = '0; wd0_w = '0;
        we1_w = 1'b0; wa1_w = '0; wd1_w = '0;
        iss_en_w = 1'b0; iss_rd_w = '0; ra_w = '0;
    endtask

    task automatic test_reset();
        idle();
        ra = {5'd1, 5'd5};
        #2;
        exp_q.push_back(64'd0);
        obs_v = rd; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_rd got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'd0);
        obs_v = {62'd0, rbusy}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_rbusy got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'd0);
        obs_v = {32'd0, link_q}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_link got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'd0);
        obs_v = {32'd0, busy_vec}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_busy_vec got=%h exp=%h", obs_v, exp_v); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        iss_en = 1'b1; iss_rd = 5'd4;
        @(negedge clk);
        idle();
        ra = {5'd4, 5'd5};
        #1;
        exp_q.push_back(64'hDEADBEEF);
        obs_v = {32'd0, rd[31:0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL mid_pre_rd got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'h10);
        obs_v = {32'd0, busy_vec}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL mid_pre_busy got=%h exp=%h", obs_v, exp_v); end
        rst = 1'b1;
        #1;
        exp_q.push_back(64'd0);
        obs_v = {32'd0, rd[31:0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL mid_rst_rd got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'd0);
        obs_v = {32'd0, busy_vec}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL mid_rst_busy got=%h exp=%h", obs_v, exp_v); end
        #4;
        rst = 1'b0;
    endtask

    task automatic test_collision();
        @(negedge clk);
        idle();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        ra = {5'd0, 5'd7};
        #1;
        exp_q.push_back(64'h22);
        obs_v = {32'd0, rd[31:0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL coll_bypass got=%h exp=%h", obs_v, exp_v); end
        @(negedge clk);
        idle();
        #1;
        exp_q.push_back(64'h22);
        obs_v = {32'd0, rd[31:0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL coll_stored got=%h exp=%h", obs_v, exp_v); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_rd = 5'd0;
        ra = {5'd0, 5'd0};
        #1;
        exp_q.push_back(64'd0);
        obs_v = rd; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL x0_same got=%h exp=%h", obs_v, exp_v); end
        @(negedge clk);
        idle();
        #1;
        exp_q.push_back(64'd0);
        obs_v = rd; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL x0_next got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'd0);
        obs_v = {32'd0, busy_vec}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL x0_busy got=%h exp=%h", obs_v, exp_v); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_rd = 5'd3;
        ra = {5'd0, 5'd3};
        #1;
        exp_q.push_back(64'd0);
        obs_v = {63'd0, rbusy[0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_issue_cycle got=%h exp=%h", obs_v, exp_v); end
        @(negedge clk);
        idle();
        #1;
        exp_q.push_back(64'd1);
        obs_v = {63'd0, rbusy[0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_busy_next got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'h8);
        obs_v = {32'd0, busy_vec}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_busy_vec got=%h exp=%h", obs_v, exp_v); end
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
        #1;
        exp_q.push_back(64'd0);
        obs_v = {63'd0, rbusy[0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_wb_rbusy got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'h55);
        obs_v = {32'd0, rd[31:0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_wb_rd got=%h exp=%h", obs_v, exp_v); end
        @(negedge clk);
        idle();
        #1;
        exp_q.push_back(64'd0);
        obs_v = {32'd0, busy_vec}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_cleared got=%h exp=%h", obs_v, exp_v); end
        iss_en = 1'b1; iss_rd = 5'd3;
        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_rd = 5'd3;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h66;
        #1;
        exp_q.push_back(64'd1);
        obs_v = {63'd0, rbusy[0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_iss_wb_rbusy got=%h exp=%h", obs_v, exp_v); end
        @(negedge clk);
        idle();
        #1;
        exp_q.push_back(64'h8);
        obs_v = {32'd0, busy_vec}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_iss_wb_busy got=%h exp=%h", obs_v, exp_v); end
        exp_q.push_back(64'h66);
        obs_v = {32'd0, rd[31:0]}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL sb_iss_wb_rd got=%h exp=%h", obs_v, exp_v); end
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
        @(negedge clk);
        idle();
    endtask

    task automatic test_link();
        @(negedge clk);
        idle();
        we1 = 1'b1; wa1 = 5'd1; wd1 = 32'h1000;
        #1;
        exp_q.push_back(64'd0);
        obs_v = {32'd0, link_q}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL link_write_cycle got=%h exp=%h", obs_v, exp_v); end
        @(negedge clk);
        idle();
        #1;
        exp_q.push_back(64'h1000);
        obs_v = {32'd0, link_q}; exp_v = exp_q.pop_front(); vectors++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL link_next got=%h exp=%h", obs_v, exp_v); end
    endtask

    task automatic test_wide();
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        @(negedge clk);
        idle();
        we0_w = 1'b1; wa0_w = 4'd15; wd0_w = a;
        we1_w = 1'b1; wa1_w = 4'd8;  wd1_w = b;
        @(negedge clk);
        idle();
        ra_w = {4'd8, 4'd0, 4'd15};
        #1;
        exp_q.push_back(a);
        exp_q.push_back(64'd0);
        exp_q.push_back(b);
        for (int k = 0; k < 3; k++) begin
            obs_v = rd_w[k*64 +: 64]; exp_v = exp_q.pop_front(); vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL wide_port%0d got=%h exp=%h", k, obs_v, exp_v); end
        end
    endtask

    task automatic test_random();
        logic [31:0] model [32];
        logic [4:0]  ra_k;
        logic [31:0] e;
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            idle();
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = 5'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0 = $urandom;
            wd1 = $urandom;
            ra[4:0] = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom_range(0, 31));
            ra[9:5] = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
            #1;
            for (int k = 0; k < 2; k++) begin
                ra_k = ra[k*5 +: 5];
                if (we1 && wa1 == ra_k && ra_k != 0)      e = wd1;
                else if (we0 && wa0 == ra_k && ra_k != 0) e = wd0;
                else                                       e = model[ra_k];
                exp_q.push_back({32'd0, e});
            end
            for (int k = 0; k < 2; k++) begin
                obs_v = {32'd0, rd[k*32 +: 32]}; exp_v = exp_q.pop_front(); vectors++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL rand_rd%0d iter=%0d got=%h exp=%h", k, n, obs_v, exp_v); end
            end
            if (we0 && wa0 != 0) model[wa0] = wd0;
            if (we1 && wa1 != 0) model[wa1] = wd1;
        end
        @(negedge clk);
        idle();
        for (int i = 1; i < 32; i++) begin
            ra[4:0] = 5'(i);
            #1;
            exp_q.push_back({32'd0, model[i]});
            obs_v = {32'd0, rd[31:0]}; exp_v = exp_q.pop_front(); vectors++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL rand_final x%0d got=%h exp=%h", i, obs_v, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_collision();
        test_x0();
        test_scoreboard();
        test_link();
        test_wide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
